// File: rtl/rlbp_timing_gen.sv
// Wishbone-programmed frame timing generator: N_CH windowed pulse channels,
// end-of-frame clear, one-shot/continuous sequencing and a comparator sampler.
module rlbp_timing_gen #(
  parameter int N_CH = 7,
  parameter int CW   = 12,
  parameter int SR_W = 8
) (
  input  logic            wb_clk_i,
  input  logic            rst,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic            start_i,
  input  logic            cmp_i,
  output logic [N_CH-1:0] ch_o,
  output logic            clr_o,
  output logic            cmp_valid_o,
  output logic [SR_W-1:0] sr_o,
  output logic            busy_o,
  output logic            irq_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   en_q, en_d;
  logic                   oneshot_q, oneshot_d;
  logic                   irq_en_q, irq_en_d;
  logic [CW-1:0]          period_q, period_d;
  logic [15:0]            frames_q, frames_d;
  logic [CW-1:0]          cmp_time_q, cmp_time_d;
  logic [N_CH-1:0]        pol_q, pol_d;
  logic [N_CH-1:0][CW-1:0] up_q, up_d;
  logic [N_CH-1:0][CW-1:0] down_q, down_d;
  logic                   done_q, done_d;
  logic [SR_W-1:0]        sr_q, sr_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0]            fcnt_q, fcnt_d;
  logic [N_CH-1:0]        ch_q, ch_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   start_q, start_d;
  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d;

  logic                   wb_sel;
  logic                   wb_acc;
  logic                   wb_wr;
  logic [7:0]             off;
  logic [31:0]            rdata;
  logic                   soft_start;
  logic                   en_eff;
  logic                   done_clr;
  logic                   sr_wr;
  logic                   start_edge;
  logic                   running;
  logic [15:0]            fcnt_inc;
  logic [15:0]            frames_eff;
  logic [SR_W-1:0]        sr_shift;
  logic                   unused_bits;

  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[27:8], wbs_dat_i[31:16]};

  // A new access is taken only when no ack is outstanding, so a held strobe
  // can never produce two consecutive acks.
  assign wb_sel     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == 4'h3);
  assign wb_acc     = wb_sel & ~ack_q;
  assign wb_wr      = wb_acc & wbs_we_i & wbs_sel_i[0];
  assign off        = wbs_adr_i[7:0];
  assign start_edge = start_i & ~start_q;
  assign running    = (state_q == RUN);
  assign fcnt_inc   = fcnt_q + 16'd1;
  assign frames_eff = (frames_q == 16'd0) ? 16'd1 : frames_q;

  generate
    if (SR_W == 1) begin : g_sr_one
      assign sr_shift = sync2_q;
    end else begin : g_sr_many
      assign sr_shift = {sr_q[SR_W-2:0], sync2_q};
    end
  endgenerate

  always_comb begin
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    irq_en_d   = irq_en_q;
    period_d   = period_q;
    frames_d   = frames_q;
    cmp_time_d = cmp_time_q;
    pol_d      = pol_q;
    up_d       = up_q;
    down_d     = down_q;
    soft_start = 1'b0;
    en_eff     = en_q;
    done_clr   = 1'b0;
    sr_wr      = 1'b0;
    if (wb_wr) begin
      case (off)
        8'h00: begin
          en_d       = wbs_dat_i[0];
          oneshot_d  = wbs_dat_i[1];
          soft_start = wbs_dat_i[2];
          irq_en_d   = wbs_dat_i[3];
          en_eff     = wbs_dat_i[0];
        end
        8'h04: period_d   = wbs_dat_i[CW-1:0];
        8'h08: frames_d   = wbs_dat_i[15:0];
        8'h0C: cmp_time_d = wbs_dat_i[CW-1:0];
        8'h10: done_clr   = wbs_dat_i[1];
        8'h14: sr_wr      = 1'b1;
        8'h18: pol_d      = wbs_dat_i[N_CH-1:0];
        default: begin
          for (int i = 0; i < N_CH; i++) begin
            if (off == 8'(32 + 8 * i)) up_d[i] = wbs_dat_i[CW-1:0];
            if (off == 8'(36 + 8 * i)) down_d[i] = wbs_dat_i[CW-1:0];
          end
        end
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      8'h00: rdata = {28'd0, irq_en_q, 1'b0, oneshot_q, en_q};
      8'h04: rdata = 32'(period_q);
      8'h08: rdata = 32'(frames_q);
      8'h0C: rdata = 32'(cmp_time_q);
      8'h10: rdata = {fcnt_q, 14'd0, done_q, running};
      8'h14: rdata = 32'(sr_q);
      8'h18: rdata = 32'(pol_q);
      default: begin
        for (int i = 0; i < N_CH; i++) begin
          if (off == 8'(32 + 8 * i)) rdata = 32'(up_q[i]);
          if (off == 8'(36 + 8 * i)) rdata = 32'(down_q[i]);
        end
      end
    endcase
    ack_d = wb_acc;
    dat_d = (wb_acc && !wbs_we_i) ? rdata : 32'd0;
  end

  // Clearing EN wins over frame bookkeeping; a DONE set wins over a W1C clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    done_d  = done_q;
    if (done_clr) done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_eff && (start_edge || soft_start)) begin
          state_d = RUN;
          cnt_d   = '0;
          fcnt_d  = '0;
        end
      end
      RUN: begin
        if (!en_eff) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == period_q) begin
          cnt_d  = '0;
          fcnt_d = fcnt_inc;
          if (oneshot_q && (fcnt_inc >= frames_eff)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_d = pol_q;
    for (int i = 0; i < N_CH; i++) begin
      if (running && (up_q[i] <= cnt_q) && (cnt_q < down_q[i])) ch_d[i] = ~pol_q[i];
    end
    sync1_d = cmp_i;
    sync2_d = sync1_q;
    start_d = start_i;
    sr_d    = sr_q;
    if (sr_wr) sr_d = wbs_dat_i[SR_W-1:0];
    else if (cmp_valid_o) sr_d = sr_shift;
  end

  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      period_q   <= '0;
      frames_q   <= '0;
      cmp_time_q <= '0;
      pol_q      <= '0;
      up_q       <= '0;
      down_q     <= '0;
      done_q     <= 1'b0;
      sr_q       <= '0;
      cnt_q      <= '0;
      fcnt_q     <= '0;
      ch_q       <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      start_q    <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      irq_en_q   <= irq_en_d;
      period_q   <= period_d;
      frames_q   <= frames_d;
      cmp_time_q <= cmp_time_d;
      pol_q      <= pol_d;
      up_q       <= up_d;
      down_q     <= down_d;
      done_q     <= done_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      ch_q       <= ch_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      start_q    <= start_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign ch_o        = ch_q;
  assign clr_o       = running && (cnt_q == period_q);
  assign cmp_valid_o = running && (cnt_q == cmp_time_q);
  assign sr_o        = sr_q;
  assign busy_o      = running;
  assign irq_o       = done_q & irq_en_q;

endmodule

// File: tb/tb_rlbp_timing_gen.sv
// Self-checking bench for rlbp_timing_gen: per-feature tasks, expected values
// queued by a small bench-side model and popped as the DUT produces them.
module tb_rlbp_timing_gen;
  localparam int N_CH = 7;
  localparam int CW   = 12;
  localparam int SR_W = 8;

  logic            wb_clk_i = 1'b0;
  logic            rst = 1'b1;
  logic            wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]      wbs_sel_i = 4'h0;
  logic [31:0]     wbs_adr_i = '0, wbs_dat_i = '0;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic            start_i = 1'b0, cmp_i = 1'b0;
  logic [N_CH-1:0] ch_o;
  logic            clr_o, cmp_valid_o, busy_o, irq_o;
  logic [SR_W-1:0] sr_o;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  rlbp_timing_gen #(.N_CH(N_CH), .CW(CW), .SR_W(SR_W)) dut (
    .wb_clk_i(wb_clk_i), .rst(rst),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .start_i(start_i), .cmp_i(cmp_i),
    .ch_o(ch_o), .clr_o(clr_o), .cmp_valid_o(cmp_valid_o),
    .sr_o(sr_o), .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wb_access(input logic we, input logic [7:0] off, input logic [31:0] data,
                           input logic [3:0] sel, output logic [31:0] rdata);
    int n = 0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = {4'h3, 20'h0, off}; wbs_dat_i = data;
    do begin tick(); n++; end while (wbs_ack_o !== 1'b1 && n < 8);
    checks++;
    if (wbs_ack_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wb_ack off=0x%02h got=%b want=1", off, wbs_ack_o);
    end
    rdata = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] data);
    logic [31:0] dummy;
    wb_access(1'b1, off, data, 4'hF, dummy);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] data);
    wb_access(1'b0, off, 32'h0, 4'hF, data);
  endtask

  task automatic test_reset();
    logic [7:0] offs [4] = '{8'h00, 8'h04, 8'h10, 8'h18};
    logic [31:0] rd;
    logic [63:0] want;
    checks++;
    if ({wbs_ack_o, wbs_dat_o, ch_o, clr_o, cmp_valid_o, sr_o, busy_o, irq_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs ack=%b dat=%h ch=%b clr=%b cv=%b sr=%h busy=%b irq=%b want all 0",
               wbs_ack_o, wbs_dat_o, ch_o, clr_o, cmp_valid_o, sr_o, busy_o, irq_o);
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(64'h0);
      wb_read(offs[i], rd);
      want = exp_q.pop_front();
      checks++;
      if (64'(rd) !== want) begin
        failures++;
        $display("[TB] FAIL reset_reg off=0x%02h got=%h want=%h", offs[i], rd, want[31:0]);
      end
    end
  endtask

  task automatic test_start_pin();
    start_i = 1'b1; tick(); tick();
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL start_without_en got=%b want=0", busy_o); end
    start_i = 1'b0;
    wb_write(8'h00, 32'h1);
    tick();
    start_i = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("[TB] FAIL start_edge got=%b want=1", busy_o); end
    repeat (3) tick();
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("[TB] FAIL start_hold got=%b want=1", busy_o); end
    start_i = 1'b0;
    wb_write(8'h00, 32'h0);
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL start_stop got=%b want=0", busy_o); end
  endtask

  task automatic test_frame();
    int clr_cnt = 0;
    int m, pm;
    logic [8:0] obs, want;
    wb_write(8'h04, 32'd9);
    wb_write(8'h20, 32'd2);
    wb_write(8'h24, 32'd5);
    wb_write(8'h00, 32'h1);
    wb_write(8'h00, 32'h5);
    for (int k = 0; k < 30; k++) begin
      m  = k % 10;
      pm = (k + 9) % 10;
      exp_q.push_back(64'({1'b1, m == 9, 6'b0, (k > 0) && pm >= 2 && pm < 5}));
    end
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      want = exp_q.pop_front();
      obs  = {busy_o, clr_o, ch_o};
      if (clr_o === 1'b1) clr_cnt++;
      checks++;
      if (obs !== want) begin
        failures++;
        $display("[TB] FAIL frame_k%0d {busy,clr,ch}=%b want=%b", k, obs, want);
      end
    end
    checks++;
    if (clr_cnt != 3) begin failures++; $display("[TB] FAIL frame_clr_count got=%0d want=3", clr_cnt); end
    wb_write(8'h00, 32'h0);
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL frame_stop got=%b want=0", busy_o); end
  endtask

  task automatic test_en_stop();
    logic [31:0] rd;
    wb_write(8'h04, 32'd9);
    wb_write(8'h00, 32'h1);
    wb_write(8'h00, 32'h5);
    repeat (5) tick();
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("[TB] FAIL en_stop_running got=%b want=1", busy_o); end
    wb_write(8'h00, 32'h0);
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL en_stop_busy got=%b want=0", busy_o); end
    exp_q.push_back(64'h0);
    wb_read(8'h10, rd);
    checks++;
    if (64'(rd) !== exp_q.pop_front()) begin failures++; $display("[TB] FAIL en_stop_status got=%h want=0", rd); end
    wb_write(8'h1C, 32'hFFFF_FFFF);
    exp_q.push_back(64'h0);
    wb_read(8'h1C, rd);
    checks++;
    if (64'(rd) !== exp_q.pop_front()) begin failures++; $display("[TB] FAIL unmapped_read got=%h want=0", rd); end
  endtask

  task automatic test_oneshot();
    int busy_cnt = 0, clr_cnt = 0;
    logic [2:0] obs, want;
    logic [31:0] rd;
    wb_write(8'h04, 32'd4);
    wb_write(8'h08, 32'd3);
    wb_write(8'h00, 32'hB);
    wb_write(8'h00, 32'hF);
    for (int k = 0; k < 20; k++)
      exp_q.push_back(64'({k < 15, (k < 15) && (k % 5 == 4), k >= 15}));
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      want = exp_q.pop_front();
      obs  = {busy_o, clr_o, irq_o};
      if (busy_o === 1'b1) busy_cnt++;
      if (clr_o === 1'b1) clr_cnt++;
      checks++;
      if (obs !== want) begin
        failures++;
        $display("[TB] FAIL oneshot_k%0d {busy,clr,irq}=%b want=%b", k, obs, want);
      end
    end
    checks++;
    if (busy_cnt != 15) begin failures++; $display("[TB] FAIL oneshot_busy_cycles got=%0d want=15", busy_cnt); end
    checks++;
    if (clr_cnt != 3) begin failures++; $display("[TB] FAIL oneshot_clr_count got=%0d want=3", clr_cnt); end
    wb_read(8'h00, rd);
    checks++;
    if (rd !== 32'hB) begin failures++; $display("[TB] FAIL ctrl_soft_start_reads0 got=%h want=b", rd); end
    wb_read(8'h10, rd);
    checks++;
    if (rd !== 32'h0003_0002) begin failures++; $display("[TB] FAIL oneshot_status got=%h want=00030002", rd); end
    wb_write(8'h10, 32'h2);
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("[TB] FAIL irq_w1c got=%b want=0", irq_o); end
    wb_read(8'h10, rd);
    checks++;
    if (rd !== 32'h0003_0000) begin failures++; $display("[TB] FAIL status_after_w1c got=%h want=00030000", rd); end
    wb_write(8'h00, 32'h0);
  endtask

  task automatic test_period_zero();
    logic [31:0] rd;
    wb_write(8'h04, 32'd0);
    wb_write(8'h00, 32'h1);
    wb_write(8'h00, 32'h5);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checks++;
      if ({busy_o, clr_o} !== 2'b11) begin
        failures++;
        $display("[TB] FAIL period0_k%0d {busy,clr}=%b want=11", k, {busy_o, clr_o});
      end
    end
    wb_write(8'h00, 32'h0);
    wb_write(8'h08, 32'd0);
    wb_write(8'h00, 32'h3);
    wb_write(8'h00, 32'h7);
    checks++;
    if ({busy_o, clr_o} !== 2'b11) begin failures++; $display("[TB] FAIL frames0_first {busy,clr}=%b want=11", {busy_o, clr_o}); end
    tick();
    checks++;
    if ({busy_o, clr_o, irq_o} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL frames0_done {busy,clr,irq}=%b want=000", {busy_o, clr_o, irq_o});
    end
    wb_read(8'h10, rd);
    checks++;
    if (rd !== 32'h0001_0002) begin failures++; $display("[TB] FAIL frames0_status got=%h want=00010002", rd); end
    wb_write(8'h10, 32'h2);
    wb_write(8'h00, 32'h0);
  endtask

  task automatic test_cmp();
    logic [3:0] pattern = 4'b1101;
    logic [SR_W-1:0] exp_sr = '0;
    int f = 0, valid_cnt = 0;
    logic [31:0] rd;
    wb_write(8'h14, 32'h0);
    wb_write(8'h04, 32'd4);
    wb_write(8'h0C, 32'd1);
    cmp_i = pattern[0];
    wb_write(8'h00, 32'h1);
    wb_write(8'h00, 32'h5);
    for (int k = 0; k < 20; k++) exp_q.push_back(64'(k % 5 == 1));
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      checks++;
      if (64'(cmp_valid_o) !== exp_q.pop_front()) begin
        failures++;
        $display("[TB] FAIL cmp_valid_k%0d got=%b want=%b", k, cmp_valid_o, k % 5 == 1);
      end
      if (cmp_valid_o === 1'b1) valid_cnt++;
      if (k % 5 == 1) begin
        exp_sr = {exp_sr[SR_W-2:0], pattern[f]};
        f++;
        if (f < 4) cmp_i = pattern[f];
      end
    end
    checks++;
    if (valid_cnt != 4) begin failures++; $display("[TB] FAIL cmp_valid_count got=%0d want=4", valid_cnt); end
    checks++;
    if (sr_o !== exp_sr) begin failures++; $display("[TB] FAIL sr_pattern got=%b want=%b", sr_o, exp_sr); end
    tick(); tick();
    checks++;
    if (cmp_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL cmp_valid_frame4 got=%b want=1", cmp_valid_o); end
    wb_write(8'h14, 32'h5A);
    checks++;
    if (sr_o !== 8'h5A) begin failures++; $display("[TB] FAIL sr_write_wins got=%h want=5a", sr_o); end
    wb_write(8'h00, 32'h0);
    wb_read(8'h14, rd);
    checks++;
    if (rd !== 32'h5A) begin failures++; $display("[TB] FAIL sr_read got=%h want=5a", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [32:0] obs;
    logic [63:0] want;
    wb_write(8'h04, 32'h7AB);
    wb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h7AB) begin failures++; $display("[TB] FAIL period_rw got=%h want=7ab", rd); end
    wb_access(1'b1, 8'h04, 32'h123, 4'hE, rd);
    wb_read(8'h04, rd);
    checks++;
    if (rd !== 32'h7AB) begin failures++; $display("[TB] FAIL sel0_gate got=%h want=7ab", rd); end
    wb_write(8'h04, 32'hFFFF_FFFF);
    tick();
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0004;
    exp_q.push_back(64'({1'b1, 32'hFFF}));
    exp_q.push_back(64'h0);
    exp_q.push_back(64'({1'b1, 32'hFFF}));
    exp_q.push_back(64'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      obs  = {wbs_ack_o, (wbs_ack_o === 1'b1) ? wbs_dat_o : 32'h0};
      want = exp_q.pop_front();
      checks++;
      if (64'(obs) !== want) begin
        failures++;
        $display("[TB] FAIL held_read_k%0d {ack,dat}=%h want=%h", k, obs, want[32:0]);
      end
    end
    wbs_adr_i = 32'h2000_0004;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL addr_decode_k%0d ack=%b want=0", k, wbs_ack_o); end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_pol();
    wb_write(8'h04, 32'd9);
    wb_write(8'h18, 32'h2);
    wb_write(8'h28, 32'd3);
    wb_write(8'h2C, 32'd3);
    tick(); tick();
    checks++;
    if (ch_o !== 7'b0000010) begin failures++; $display("[TB] FAIL pol_idle got=%b want=0000010", ch_o); end
    wb_write(8'h00, 32'h1);
    wb_write(8'h00, 32'h5);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      checks++;
      if (ch_o[1] !== 1'b1) begin failures++; $display("[TB] FAIL pol_run_k%0d ch1=%b want=1", k, ch_o[1]); end
    end
    wb_write(8'h00, 32'h0);
    tick();
    checks++;
    if (ch_o[1] !== 1'b1) begin failures++; $display("[TB] FAIL pol_after_run ch1=%b want=1", ch_o[1]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    wb_write(8'h00, 32'h9);
    wb_write(8'h00, 32'hD);
    repeat (3) tick();
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0004;
    rst = 1'b1;
    tick();
    checks++;
    if ({wbs_ack_o, wbs_dat_o, ch_o, clr_o, cmp_valid_o, sr_o, busy_o, irq_o} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs ack=%b dat=%h ch=%b clr=%b cv=%b sr=%h busy=%b irq=%b want all 0",
               wbs_ack_o, wbs_dat_o, ch_o, clr_o, cmp_valid_o, sr_o, busy_o, irq_o);
    end
    rst = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
    wb_read(8'h00, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_mid_ctrl got=%h want=0", rd); end
    wb_read(8'h18, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_mid_pol got=%h want=0", rd); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    test_reset();
    test_start_pin();
    test_frame();
    test_en_stop();
    test_oneshot();
    test_period_zero();
    test_cmp();
    test_back_to_back();
    test_pol();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rlbp_timing_gen.md
RLBP_TIMING_GEN -- requirements
Module: rlbp_timing_gen

Interface
REQ-001 Parameter N_CH, default 7, SHALL set the number of programmable timing channels (1..16).
REQ-002 Parameter CW, default 12, SHALL set the frame-counter and timing-register width (4..16).
REQ-003 Parameter SR_W, default 8, SHALL set the comparator sample shift-register depth (1..32).
REQ-004 wb_clk_i  in  1  sole clock; all state on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
REQ-007 wbs_sel_i  in  4; wbs_adr_i  in  32; wbs_dat_i  in  32  Wishbone select/address/write data.
REQ-008 wbs_ack_o  out  1; wbs_dat_o  out  32  Wishbone acknowledge/read data.
REQ-009 start_i  in  1  external frame-start request, already synchronous to wb_clk_i.
REQ-010 cmp_i  in  1  asynchronous comparator output.
REQ-011 ch_o  out  N_CH  channel timing pulses; clr_o  out  1  end-of-frame pulse; cmp_valid_o  out  1  sample strobe.
REQ-012 sr_o  out  SR_W  sample shift register; busy_o  out  1  RUN state; irq_o  out  1  done interrupt.

Function
REQ-013 Slave selected when cyc&stb and adr[31:28]==4'h3; offset = adr[7:0]; registers written only when we and sel[0]; values zero-extended on read.
REQ-014 Map: 0x00 CTRL{[0]EN,[1]ONESHOT,[2]SOFT_START (self-clearing, reads 0),[3]IRQ_EN}; 0x04 PERIOD; 0x08 FRAMES[15:0]; 0x0C CMP_TIME; 0x10 STATUS{[0]busy,[1]DONE (W1C),[31:16]frame count} ; 0x14 SR; 0x18 POL[N_CH-1:0]; 0x20+8*i UP_i; 0x24+8*i DOWN_i, i<N_CH.
REQ-015 Unmapped offsets SHALL ack, read 0, ignore writes.
REQ-016 wbs_ack_o SHALL pulse exactly one cycle, the cycle after selection; ack never asserted two consecutive cycles; read data valid with ack.
REQ-017 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE->RUN when EN=1 and (rising edge of start_i or SOFT_START write); counter loads 0, frame count loads 0.
REQ-019 RUN: counter +1 per cycle; when counter==PERIOD, clr_o pulses that cycle, counter->0, frame count +1 (wraps at 16 bits).
REQ-020 RUN with ONESHOT=1: at the clr_o cycle where frame count+1 >= max(FRAMES,1), go DONE; ONESHOT=0 runs until EN cleared.
REQ-021 DONE: set STATUS.DONE, go IDLE next cycle; irq_o = DONE & IRQ_EN (level).
REQ-022 EN written 0 in RUN: go IDLE next cycle, counter 0, DONE not set.
REQ-023 PERIOD=0: clr_o every RUN cycle, counter stays 0.
REQ-024 ch_o[i] SHALL be registered: next = POL[i] XOR (RUN and UP_i <= counter < DOWN_i); UP_i>=DOWN_i gives inactive; latency one cycle from counter value.
REQ-025 In IDLE/DONE ch_o[i] SHALL equal POL[i].
REQ-026 cmp_i passes a two-flop synchronizer; cmp_valid_o pulses (combinational) in RUN when counter==CMP_TIME; same cycle sr <= {sr[SR_W-2:0], cmp_sync} (SR_W=1: sr<=cmp_sync).
REQ-027 Simultaneous Wishbone SR write and sample: write wins.
REQ-028 Timing register writes in RUN SHALL take effect the next cycle (no shadowing).
REQ-029 busy_o = (state==RUN); sr_o = SR register.

Reset
REQ-030 rst SHALL clear all registers, FSM to IDLE, synchronizer flops 0; POL=0 so ch_o=0; clr_o, cmp_valid_o, busy_o, irq_o, wbs_ack_o = 0; wbs_dat_o = 0.
REQ-031 rst asserted mid-RUN or mid-Wishbone cycle SHALL abort without ack; outputs reach reset values on the next edge.

Verification
REQ-032 PERIOD=9, UP_0=2, DOWN_0=5, EN, soft start -> ch_o[0] high during cycles with counter 3..5 view (counter 2..4 + 1 latency), clr_o every 10 cycles.
REQ-033 ONESHOT, FRAMES=3, PERIOD=4 -> exactly 3 clr_o pulses, busy_o 15 cycles, STATUS.DONE=1, irq_o=1 if IRQ_EN; W1C to 0x10 clears irq_o.
REQ-034 CMP_TIME=1, cmp_i pattern 1,0,1,1 over 4 frames -> sr_o[3:0]=4'b1011, cmp_valid_o 4 pulses.
REQ-035 POL[1]=1, UP_1=DOWN_1=3 -> ch_o[1] stays 1 across run and idle.
REQ-036 EN cleared at counter 5 of continuous run -> busy_o 0 next cycle, DONE stays 0; read unmapped 0x1C -> ack, data 0.
REQ-037 rst pulse mid-frame -> all outputs 0 next cycle, CTRL reads 0.
